// File: rtl/gradient_pkg.sv
// gradient_pkg: shared state type and default geometry for the Prewitt gradient path
package gradient_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} win_state_t;
  localparam int DEF_KERNEL_SIZE = 5;
  localparam int DEF_IMG_WIDTH = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int COL_W = $clog2(DEF_IMG_WIDTH);
  localparam int ROW_W = $clog2(DEF_IMG_HEIGHT);
endpackage

// File: rtl/gradient_xy_counter.sv
// gradient_xy_counter: col/row position of the last accepted pixel, with next-pixel flags
module gradient_xy_counter import gradient_pkg::*; #(
  parameter int W = DEF_IMG_WIDTH,
  parameter int H = DEF_IMG_HEIGHT,
  parameter int CW = COL_W,
  parameter int RW = ROW_W
) (
  input  logic          i_clk,
  input  logic          i_aresetn,
  input  logic          load_zero,
  input  logic          inc,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [CW-1:0] nxt_col,
  output logic [RW-1:0] nxt_row,
  output logic          eol,
  output logic          eof
);
  logic wrap;
  // nxt_* is the position the next accepted pixel will take; flags describe that pixel
  assign wrap = col == CW'(W - 1);
  assign nxt_col = wrap ? '0 : col + 1'b1;
  assign nxt_row = wrap ? row + 1'b1 : row;
  assign eol = nxt_col == CW'(W - 1);
  assign eof = eol && nxt_row == RW'(H - 1);
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      col <= '0;
      row <= '0;
    end else if (load_zero) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      col <= nxt_col;
      row <= nxt_row;
    end
  end
endmodule

// File: rtl/gradient_window_ctrl.sv
// gradient_window_ctrl: frame/window sequencer qualifying fully populated 5x5 windows
module gradient_window_ctrl import gradient_pkg::*; #(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
  input  logic                          i_clk,
  input  logic                          i_aresetn,
  input  logic                          i_pixel_valid,
  input  logic                          i_sof,
  output logic                          o_ready,
  output logic                          o_shift_en,
  output logic                          o_window_valid,
  output logic                          o_window_sof,
  output logic [$clog2(IMG_WIDTH)-1:0]  o_col,
  output logic [$clog2(IMG_HEIGHT)-1:0] o_row,
  output logic                          o_frame_done,
  output logic                          o_frame_abort,
  output logic [15:0]                   o_frame_cnt
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  win_state_t state, nxt_state;
  logic accept, active, load_zero, inc, abort, last, win, eol, eof;
  logic [CW-1:0] nxt_col;
  logic [RW-1:0] nxt_row;
  // ready is gated by reset so nothing is accepted while the block is held in reset
  assign o_ready = i_aresetn && state != DONE;
  assign accept = i_pixel_valid && o_ready;
  assign o_shift_en = accept;
  assign active = state == FILL || state == RUN;
  assign load_zero = accept && i_sof;
  assign inc = accept && active && !i_sof;
  assign abort = accept && active && i_sof;
  assign last = inc && state == RUN && eof;
  assign win = inc && nxt_col >= CW'(KERNEL_SIZE - 1) && nxt_row >= RW'(KERNEL_SIZE - 1);
  gradient_xy_counter #(.W(IMG_WIDTH), .H(IMG_HEIGHT), .CW(CW), .RW(RW)) u_xy (
    .i_clk(i_clk),
    .i_aresetn(i_aresetn),
    .load_zero(load_zero),
    .inc(inc),
    .col(o_col),
    .row(o_row),
    .nxt_col(nxt_col),
    .nxt_row(nxt_row),
    .eol(eol),
    .eof(eof)
  );
  always_comb begin
    nxt_state = load_zero ? FILL :
                state == DONE ? IDLE :
                (inc && state == FILL && eol && nxt_row == RW'(KERNEL_SIZE - 2)) ? RUN :
                last ? DONE : state;
  end
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state <= IDLE;
      o_window_valid <= 1'b0;
      o_window_sof <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_abort <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      state <= nxt_state;
      o_window_valid <= win;
      o_window_sof <= win && nxt_col == CW'(KERNEL_SIZE - 1) && nxt_row == RW'(KERNEL_SIZE - 1);
      o_frame_done <= last;
      o_frame_abort <= abort;
      o_frame_cnt <= o_frame_cnt + 16'(last);
    end
  end
endmodule

// File: tb/tb_gradient_window_ctrl.sv
// tb_gradient_window_ctrl: directed vectors and frame sequences for the window sequencer
module tb_gradient_window_ctrl;
  localparam int W = 8, H = 6, K = 5;
  logic i_clk = 1'b0, i_aresetn = 1'b0, i_pixel_valid = 1'b0, i_sof = 1'b0;
  logic o_ready, o_shift_en, o_window_valid, o_window_sof, o_frame_done, o_frame_abort;
  logic [2:0] o_col, o_row;
  logic [15:0] o_frame_cnt;
  int n_chk = 0, n_fail = 0, m_row = 0, m_col = 0, m_cnt = 0;
  typedef struct {bit v, s, acc, wv, ab; int row, col;} vec_t;
  vec_t tbl[17];
  always #5 i_clk = ~i_clk;
  gradient_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K)) dut (
    .i_clk(i_clk),
    .i_aresetn(i_aresetn),
    .i_pixel_valid(i_pixel_valid),
    .i_sof(i_sof),
    .o_ready(o_ready),
    .o_shift_en(o_shift_en),
    .o_window_valid(o_window_valid),
    .o_window_sof(o_window_sof),
    .o_col(o_col),
    .o_row(o_row),
    .o_frame_done(o_frame_done),
    .o_frame_abort(o_frame_abort),
    .o_frame_cnt(o_frame_cnt)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic finish_tb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask
  // drive on the falling edge, report acceptance, return just after the rising edge
  task automatic cyc(input bit v, input bit s, output bit acc);
    @(negedge i_clk);
    i_pixel_valid = v;
    i_sof = s;
    #1 acc = o_shift_en;
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, int'(o_ready), 0);
    chk({nm, "_shift"}, int'(o_shift_en), 0);
    chk({nm, "_wv"}, int'(o_window_valid), 0);
    chk({nm, "_wsof"}, int'(o_window_sof), 0);
    chk({nm, "_row"}, int'(o_row), 0);
    chk({nm, "_col"}, int'(o_col), 0);
    chk({nm, "_done"}, int'(o_frame_done), 0);
    chk({nm, "_abort"}, int'(o_frame_abort), 0);
    chk({nm, "_cnt"}, int'(o_frame_cnt), 0);
  endtask
  task automatic send_frame(input int n, input bit gaps, input bit abort_first, input int exp_stall, input bit chain);
    int wins, sofs, stalls, r, c, tries;
    bit acc, v;
    wins = 0;
    sofs = 0;
    stalls = 0;
    for (int p = 0; p < n; p++) begin
      r = p / W;
      c = p % W;
      tries = 0;
      acc = 1'b0;
      while (!acc) begin
        v = !(gaps && $urandom_range(0, 1) == 0);
        cyc(v, p == 0, acc);
        if (!acc) begin
          if (v) stalls++;
          chk("hold_row", int'(o_row), m_row);
          chk("hold_col", int'(o_col), m_col);
          chk("hold_wv", int'(o_window_valid), 0);
          chk("hold_done", int'(o_frame_done), 0);
          if (++tries > 64) begin
            n_fail++;
            $display("FAIL accept_timeout: pixel %0d not accepted, expected acceptance within 64 cycles", p);
            finish_tb();
          end
        end
      end
      m_row = r;
      m_col = c;
      if (p == W * H - 1) m_cnt = (m_cnt + 1) % 65536;
      chk($sformatf("p%0d_row", p), int'(o_row), r);
      chk($sformatf("p%0d_col", p), int'(o_col), c);
      chk($sformatf("p%0d_wv", p), int'(o_window_valid), int'(r >= K - 1 && c >= K - 1));
      chk($sformatf("p%0d_wsof", p), int'(o_window_sof), int'(p == (K - 1) * W + K - 1));
      chk($sformatf("p%0d_done", p), int'(o_frame_done), int'(p == W * H - 1));
      chk($sformatf("p%0d_abort", p), int'(o_frame_abort), int'(p == 0 && abort_first));
      chk($sformatf("p%0d_cnt", p), int'(o_frame_cnt), m_cnt);
      wins += int'(o_window_valid);
      sofs += int'(o_window_sof);
    end
    chk("stall_cycles", stalls, exp_stall);
    if (n == W * H) begin
      chk("done_cycle_ready", int'(o_ready), 0);
      chk("window_count", wins, 8);
      chk("window_sof_count", sofs, 1);
      if (!chain) begin
        cyc(1'b0, 1'b0, acc);
        chk("post_done_ready", int'(o_ready), 1);
        chk("post_done_pulse", int'(o_frame_done), 0);
      end
    end
  endtask
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    finish_tb();
  end
  initial begin
    bit acc;
    for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
    i_pixel_valid = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 chk_zero("rst");
    @(negedge i_clk);
    i_aresetn = 1'b1;
    i_pixel_valid = 1'b0;
    #1 chk("ready_after_rst", int'(o_ready), 1);
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].v, tbl[i].s, acc);
      chk($sformatf("tbl%0d_acc", i), int'(acc), int'(tbl[i].acc));
      chk($sformatf("tbl%0d_row", i), int'(o_row), tbl[i].row);
      chk($sformatf("tbl%0d_col", i), int'(o_col), tbl[i].col);
      chk($sformatf("tbl%0d_wv", i), int'(o_window_valid), int'(tbl[i].wv));
      chk($sformatf("tbl%0d_abort", i), int'(o_frame_abort), int'(tbl[i].ab));
      chk($sformatf("tbl%0d_done", i), int'(o_frame_done), 0);
      chk($sformatf("tbl%0d_cnt", i), int'(o_frame_cnt), 0);
    end
    m_row = 0;
    m_col = 1;
    send_frame(W * H, 1'b0, 1'b1, 0, 1'b0);
    chk("cnt_first_frame", int'(o_frame_cnt), 1);
    send_frame(W * H, 1'b1, 1'b0, 0, 1'b0);
    send_frame(30, 1'b0, 1'b0, 0, 1'b0);
    send_frame(W * H, 1'b0, 1'b1, 0, 1'b0);
    chk("cnt_after_abort", int'(o_frame_cnt), 3);
    send_frame(40, 1'b0, 1'b0, 0, 1'b0);
    @(negedge i_clk);
    i_aresetn = 1'b0;
    i_pixel_valid = 1'b1;
    i_sof = 1'b0;
    #1 chk_zero("midrst");
    @(posedge i_clk);
    #1 chk_zero("midrst_hold");
    @(negedge i_clk);
    i_aresetn = 1'b1;
    i_pixel_valid = 1'b0;
    m_row = 0;
    m_col = 0;
    m_cnt = 0;
    #1 chk("ready_after_midrst", int'(o_ready), 1);
    @(posedge i_clk);
    #1 chk("midrst_no_done", int'(o_frame_done), 0);
    chk("midrst_no_abort", int'(o_frame_abort), 0);
    send_frame(W * H, 1'b0, 1'b0, 0, 1'b0);
    chk("cnt_after_midrst", int'(o_frame_cnt), 1);
    send_frame(W * H, 1'b0, 1'b0, 0, 1'b1);
    send_frame(W * H, 1'b0, 1'b0, 1, 1'b0);
    chk("cnt_back_to_back", int'(o_frame_cnt), 3);
    finish_tb();
  end
endmodule
